// File: rtl/pc_stack_unit.sv
// Program counter with relative/absolute branches, a call/return stack,
// stall, a programmable reset vector and sticky stack-error flags.
// The decoder issues one-hot-ish commands; a fixed priority picks the
// single action executed each cycle, and pc_next shows its result early.
module pc_stack_unit #(
    parameter int              ADDR_W      = 8,
    parameter int              STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               stall,
    input  logic                               advance,
    input  logic                               branch_abs,
    input  logic                               branch_rel,
    input  logic                               call,
    input  logic                               ret,
    input  logic [ADDR_W-1:0]                  target,
    input  logic [ADDR_W-1:0]                  offset,
    input  logic                               err_clr,
    output logic [ADDR_W-1:0]                  pc,
    output logic [ADDR_W-1:0]                  pc_next,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               err_overflow,
    output logic                               err_underflow
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0]                    pc_reg;
    logic [DEPTH_W-1:0]                   depth_reg;
    logic [DEPTH_W-1:0]                   depth_next;
    logic                                 ovf_reg;
    logic                                 ovf_next;
    logic                                 unf_reg;
    logic                                 unf_next;
    logic                                 push_en;
    logic [ADDR_W-1:0]                    ret_addr;
    logic [ADDR_W-1:0]                    top_entry;
    logic [STACK_DEPTH-1:0][ADDR_W-1:0]   entries;
    logic                                 full;
    logic                                 empty;

    // Return address is the instruction after the call; wraps naturally.
    assign ret_addr = pc_reg + ADDR_W'(1);
    assign full     = (depth_reg == DEPTH_W'(STACK_DEPTH));
    assign empty    = (depth_reg == '0);

    // Stack entry gi holds the return address pushed when depth was gi.
    // Contents are don't-care after reset, so the entries carry no reset.
    for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
        logic [ADDR_W-1:0] entry_reg;

        // Capture the return address when this slot is the next free one.
        always_ff @(posedge clk) begin
            if (push_en && (depth_reg == DEPTH_W'(gi))) begin
                entry_reg <= ret_addr;
            end
        end

        assign entries[gi] = entry_reg;
    end

    // Select the most recently pushed entry (slot depth-1).
    always_comb begin
        top_entry = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth_reg == DEPTH_W'(i + 1)) begin
                top_entry = entries[i];
            end
        end
    end

    // Priority decode: stall > ret > call > branch_abs > branch_rel > advance.
    // Error cases hold pc; err_clr is applied first so a new error wins.
    always_comb begin
        pc_next    = pc_reg;
        depth_next = depth_reg;
        push_en    = 1'b0;
        ovf_next   = err_clr ? 1'b0 : ovf_reg;
        unf_next   = err_clr ? 1'b0 : unf_reg;
        if (stall) begin
            pc_next = pc_reg;
        end else if (ret) begin
            if (empty) begin
                unf_next = 1'b1;
            end else begin
                pc_next    = top_entry;
                depth_next = depth_reg - DEPTH_W'(1);
            end
        end else if (call) begin
            if (full) begin
                ovf_next = 1'b1;
            end else begin
                push_en    = 1'b1;
                pc_next    = target;
                depth_next = depth_reg + DEPTH_W'(1);
            end
        end else if (branch_abs) begin
            pc_next = target;
        end else if (branch_rel) begin
            // Modular add gives the sign-extended relative jump for free.
            pc_next = pc_reg + offset;
        end else if (advance) begin
            pc_next = pc_reg + ADDR_W'(1);
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg    <= RESET_VEC;
            depth_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            depth_reg <= depth_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    assign pc            = pc_reg;
    assign stack_depth   = depth_reg;
    assign stack_full    = full;
    assign stack_empty   = empty;
    assign err_overflow  = ovf_reg;
    assign err_underflow = unf_reg;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: a queue-based reference model is
// compared with the DUT every cycle, plus hand-computed directed checks.
module tb_pc_stack_unit;

    localparam int          AW   = 8;
    localparam int          SD   = 4;
    localparam logic [7:0]  RVEC = 8'h10;

    logic       clk;
    logic       rst_n;
    logic       stall, advance, branch_abs, branch_rel, call, ret, err_clr;
    logic [7:0] target, offset;
    logic [7:0] pc, pc_next;
    logic [2:0] stack_depth;
    logic       stack_full, stack_empty, err_overflow, err_underflow;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] m_pc;
    logic [7:0] m_stk[$];
    logic       m_ovf, m_unf;

    pc_stack_unit #(.ADDR_W(AW), .STACK_DEPTH(SD), .RESET_VEC(RVEC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .advance(advance),
        .branch_abs(branch_abs), .branch_rel(branch_rel), .call(call),
        .ret(ret), .target(target), .offset(offset), .err_clr(err_clr),
        .pc(pc), .pc_next(pc_next), .stack_depth(stack_depth),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmd(input logic st, input logic rt, input logic cl, input logic ba,
                       input logic br, input logic adv, input logic [7:0] tg,
                       input logic [7:0] of, input logic ec);
        stall = st; ret = rt; call = cl; branch_abs = ba; branch_rel = br;
        advance = adv; target = tg; offset = of; err_clr = ec;
    endtask

    task automatic idle();
        cmd(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    endtask

    // Compare DUT to the model mid-cycle, then advance the model by the
    // command that the next rising edge will execute.
    task automatic check_and_predict();
        logic [7:0] nxt;
        logic       n_ovf, n_unf;
        int         off;
        if (!rst_n) begin
            m_pc = RVEC;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        chk("pc", 32'(pc), 32'(m_pc));
        chk("depth", 32'(stack_depth), 32'(m_stk.size()));
        chk("full", 32'(stack_full), 32'(m_stk.size() == SD));
        chk("empty", 32'(stack_empty), 32'(m_stk.size() == 0));
        chk("err_ovf", 32'(err_overflow), 32'(m_ovf));
        chk("err_unf", 32'(err_underflow), 32'(m_unf));
        if (rst_n) begin
            nxt   = m_pc;
            n_ovf = err_clr ? 1'b0 : m_ovf;
            n_unf = err_clr ? 1'b0 : m_unf;
            if (stall) begin
                nxt = m_pc;
            end else if (ret) begin
                if (m_stk.size() == 0) n_unf = 1'b1;
                else nxt = m_stk.pop_back();
            end else if (call) begin
                if (m_stk.size() == SD) begin
                    n_ovf = 1'b1;
                end else begin
                    m_stk.push_back(8'((int'(m_pc) + 1) % 256));
                    nxt = target;
                end
            end else if (branch_abs) begin
                nxt = target;
            end else if (branch_rel) begin
                off = offset[7] ? int'(offset) - 256 : int'(offset);
                nxt = 8'((int'(m_pc) + off + 256) % 256);
            end else if (advance) begin
                nxt = 8'((int'(m_pc) + 1) % 256);
            end
            chk("pc_next", 32'(pc_next), 32'(nxt));
            m_pc  = nxt;
            m_ovf = n_ovf;
            m_unf = n_unf;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_and_predict();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        m_pc = RVEC; m_ovf = 0; m_unf = 0;
        @(posedge clk); #1;
        chk("rst_pc", 32'(pc), 32'h10);
        chk("rst_depth", 32'(stack_depth), 32'd0);
        chk("rst_empty", 32'(stack_empty), 32'd1);
        tick();
        rst_n = 1'b1;

        // Reset vector then sequential advance
        cmd(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0);
        tick(); $display("advance -> pc=%0h", pc); chk("adv1", 32'(pc), 32'h11);
        tick(); $display("advance -> pc=%0h", pc); chk("adv2", 32'(pc), 32'h12);
        tick(); $display("advance -> pc=%0h", pc); chk("adv3", 32'(pc), 32'h13);
        // Asynchronous reset mid-sequence
        #1 rst_n = 1'b0;
        #1;
        $display("async reset -> pc=%0h depth=%0d", pc, stack_depth);
        chk("async_rst_pc", 32'(pc), 32'h10);
        chk("async_rst_depth", 32'(stack_depth), 32'd0);
        tick();
        rst_n = 1'b1;

        // Wrap and relative branches
        cmd(0, 0, 0, 1, 0, 0, 8'hFF, 8'h00, 0); tick();
        cmd(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0); tick();
        $display("advance from FF -> pc=%0h", pc); chk("wrap", 32'(pc), 32'h00);
        cmd(0, 0, 0, 1, 0, 0, 8'h05, 8'h00, 0); tick();
        cmd(0, 0, 0, 0, 1, 0, 8'h00, 8'hFD, 0); tick();
        $display("rel 05+FD -> pc=%0h", pc); chk("rel_neg", 32'(pc), 32'h02);
        cmd(0, 0, 0, 1, 0, 0, 8'hFE, 8'h00, 0); tick();
        cmd(0, 0, 0, 0, 1, 0, 8'h00, 8'h04, 0); tick();
        $display("rel FE+04 -> pc=%0h", pc); chk("rel_wrap", 32'(pc), 32'h02);

        // Nested call/return
        cmd(0, 0, 0, 1, 0, 0, 8'h20, 8'h00, 0); tick();
        cmd(0, 0, 1, 0, 0, 0, 8'h40, 8'h00, 0); tick();
        cmd(0, 0, 1, 0, 0, 0, 8'h60, 8'h00, 0); tick();
        $display("call x2 -> pc=%0h depth=%0d", pc, stack_depth);
        chk("nest_pc", 32'(pc), 32'h60);
        chk("nest_depth", 32'(stack_depth), 32'd2);
        cmd(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0); tick();
        $display("ret -> pc=%0h", pc); chk("ret1", 32'(pc), 32'h41);
        tick();
        $display("ret -> pc=%0h depth=%0d", pc, stack_depth);
        chk("ret2", 32'(pc), 32'h21);
        chk("ret2_empty", 32'(stack_empty), 32'd1);

        // Overflow
        for (int i = 1; i <= 4; i++) begin
            cmd(0, 0, 1, 0, 0, 0, 8'(i), 8'h00, 0); tick();
        end
        chk("full", 32'(stack_full), 32'd1);
        cmd(0, 0, 1, 0, 0, 0, 8'h99, 8'h00, 0); tick();
        $display("call while full -> pc=%0h ovf=%0b", pc, err_overflow);
        chk("ovf_pc", 32'(pc), 32'h04);
        chk("ovf_flag", 32'(err_overflow), 32'd1);
        // Underflow
        cmd(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0);
        repeat (4) tick();
        chk("pop_all_pc", 32'(pc), 32'h22);
        tick();
        $display("ret while empty -> pc=%0h unf=%0b", pc, err_underflow);
        chk("unf_pc", 32'(pc), 32'h22);
        chk("unf_flag", 32'(err_underflow), 32'd1);
        chk("ovf_sticky", 32'(err_overflow), 32'd1);
        cmd(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1); tick();
        $display("err_clr -> ovf=%0b unf=%0b", err_overflow, err_underflow);
        chk("clr_ovf", 32'(err_overflow), 32'd0);
        chk("clr_unf", 32'(err_underflow), 32'd0);
        // Set wins over clear
        cmd(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 1); tick();
        chk("set_wins", 32'(err_underflow), 32'd1);
        cmd(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1); tick();
        chk("stall_clr", 32'(err_underflow), 32'd0);

        // Priority and stall
        cmd(0, 0, 1, 1, 0, 1, 8'h30, 8'h00, 0); tick();
        $display("call+abs+adv -> pc=%0h depth=%0d", pc, stack_depth);
        chk("prio_pc", 32'(pc), 32'h30);
        chk("prio_depth", 32'(stack_depth), 32'd1);
        cmd(1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0); tick();
        chk("stall_pc", 32'(pc), 32'h30);
        chk("stall_depth", 32'(stack_depth), 32'd1);
        cmd(0, 1, 1, 0, 0, 0, 8'h50, 8'h00, 0); tick();
        $display("ret+call -> pc=%0h depth=%0d", pc, stack_depth);
        chk("retcall_pc", 32'(pc), 32'h23);
        chk("retcall_depth", 32'(stack_depth), 32'd0);

        // Random command mix, scoreboarded every cycle
        for (int n = 0; n < 400; n++) begin
            cmd($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0,
                8'($urandom), 8'($urandom), $urandom_range(0, 11) == 0);
            tick();
            if (n % 50 == 0) $display("random step %0d pc=%0h depth=%0d", n, pc, stack_depth);
        end
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Parametrised program counter for the sequencer core, succeeding the fixed 8-bit PC with branch/advance.
- Adds relative branches, a hardware call/return stack, stall, a programmable reset vector, and sticky stack-error flags.
- Sits between the instruction decoder (commands) and instruction memory (address).

Parameters:
ADDR_W, 8, width of pc, targets, offsets and stack entries
STACK_DEPTH, 4, number of return-address entries (>=1)
RESET_VEC, 0, value loaded into pc on reset (ADDR_W bits)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  freeze pc and stack this cycle
advance  in  1  sequential step (pc+1)
branch_abs  in  1  absolute jump to target
branch_rel  in  1  relative jump by offset
call  in  1  push return address, jump to target
ret  in  1  pop return address into pc
target  in  ADDR_W  absolute destination for branch_abs/call
offset  in  ADDR_W  two's-complement offset for branch_rel
err_clr  in  1  clears sticky error flags
pc  out  ADDR_W  current program counter (registered)
pc_next  out  ADDR_W  combinational value pc will take at next edge
stack_depth  out  $clog2(STACK_DEPTH+1)  entries in use (registered)
stack_full  out  1  stack_depth == STACK_DEPTH
stack_empty  out  1  stack_depth == 0
err_overflow  out  1  sticky: call attempted while full
err_underflow  out  1  sticky: ret attempted while empty

Behaviour:
Reset (asynchronous, any time including mid-operation):
- pc = RESET_VEC, stack_depth = 0, err flags = 0.
- Stack contents are don't-care.
- First command takes effect at the first rising edge after rst_n deasserts.

Command priority per cycle (highest first); exactly one action executes:
- stall > ret > call > branch_abs > branch_rel > advance > hold.
- Lower-priority inputs asserted alongside are ignored, with no side effects.

Actions (all take effect at the rising edge; pc latency is 1 cycle):
- stall: pc, stack and flags unchanged. err_clr still honoured.
- ret, depth>0: pc <= top entry; depth decrements.
- ret, depth==0: pc holds; err_underflow <= 1.
- call, depth<STACK_DEPTH: push (pc+1) mod 2^ADDR_W; pc <= target; depth increments.
- call, full: no push, pc holds; err_overflow <= 1.
- branch_abs: pc <= target.
- branch_rel: pc <= (pc + offset) mod 2^ADDR_W, where offset is sign-interpreted.
- advance: pc <= (pc + 1) mod 2^ADDR_W; all-ones wraps to 0.
- none asserted: pc holds.

Stack:
- LIFO, register array indexed by depth.
- stack_full and stack_empty are derived from the registered depth.

pc_next:
- Reflects exactly the value the above rules will load.
- Equals pc when stall is asserted or on an error case.

Error flags:
- Set on the edge of the failing command.
- Remain set until err_clr is sampled high.
- If err_clr and a new error occur in the same cycle, the set wins.

Other:
- No wrap or saturation of the stack pointer beyond the above rules.
- Depth never exceeds STACK_DEPTH and never goes negative.

Test Plan:
- Reset/advance: reset with RESET_VEC=8'h10, then advance for 3 cycles -> pc 10,11,12,13. Assert rst_n low mid-sequence -> pc=10 immediately, depth=0.
- Wrap and relative branch: pc=FF, advance -> 00. pc=05, branch_rel offset=8'hFD -> 02. pc=FE, offset=8'h04 -> 02.
- Nested call/return: at pc=20 call target=40; at 40 call target=60 -> depth=2. Then ret -> pc=41, ret -> pc=21, depth=0, stack_empty=1.
- Overflow/underflow: 4 calls -> stack_full=1. Fifth call target=99 -> pc unchanged, err_overflow=1. 4 rets, then a fifth -> pc unchanged, err_underflow=1. err_clr -> both 0.
- Priority/stall: call+branch_abs+advance together -> call only, one push. stall+ret -> no pop, pc unchanged. ret+call with depth=1 -> pop only, depth=0.
- pc_next check: every cycle of a random command mix, pc at the next edge must equal the previous pc_next (scoreboarded against a reference model).
